// File: rtl/bus_arb_pkg.sv
// Shared types and helpers for the bus write arbiter.
// Holds the FSM state encoding, counter width and index-width helper.
package bus_arb_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } state_t;

  localparam int CNT_W = 16;

  // Index width for n requesters; never narrower than one bit.
  function automatic int idx_w(input int n);
    return (n > 2) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/bus_arb_rr.sv
// Combinational round-robin arbiter.
// Search starts one past last_grant and wraps upward.
module rr_arbiter
  import bus_arb_pkg::*;
#(
  parameter  int NUM_REQ = 4,
  localparam int IW      = idx_w(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [IW-1:0]      last_grant,
  output logic [NUM_REQ-1:0] grant,
  output logic [IW-1:0]      grant_idx,
  output logic               any_valid
);

  // First set request bit after last_grant, ascending with wrap.
  always_comb begin
    logic          found;
    logic [IW-1:0] idx;
    found     = 1'b0;
    idx       = '0;
    grant     = '0;
    grant_idx = '0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      idx = IW'((int'(last_grant) + k) % NUM_REQ);
      if (!found && req[idx]) begin
        found      = 1'b1;
        grant[idx] = 1'b1;
        grant_idx  = idx;
      end
    end
    any_valid = found;
  end

endmodule

// File: rtl/bus_write_arbiter.sv
// Round-robin sharing of one slave write port.
// Accept, issue, wait for ack or timeout, respond.
module bus_write_arbiter
  import bus_arb_pkg::*;
#(
  parameter  int NUM_REQ = 4,
  parameter  int ADDR_W  = 32,
  parameter  int DATA_W  = 32,
  parameter  int TIMEOUT = 255,
  localparam int IW      = idx_w(NUM_REQ)
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [NUM_REQ-1:0]        req_valid,
  output logic [NUM_REQ-1:0]        req_ready,
  input  logic [NUM_REQ*ADDR_W-1:0] req_addr,
  input  logic [NUM_REQ*DATA_W-1:0] req_data,
  output logic [NUM_REQ-1:0]        rsp_valid,
  output logic                      rsp_err,
  output logic                      slv_req,
  output logic [ADDR_W-1:0]         slv_addr,
  output logic [DATA_W-1:0]         slv_data,
  input  logic                      slv_ack,
  input  logic                      slv_err,
  output logic                      busy,
  output logic [IW-1:0]             grant_id,
  output logic [CNT_W-1:0]          txn_count,
  output logic [CNT_W-1:0]          err_count
);

  localparam logic [CNT_W-1:0] TMO_LAST = CNT_W'(TIMEOUT - 1);
  localparam logic [IW-1:0]    LG_RST   = IW'(NUM_REQ - 1);

  state_t              state_q;
  state_t              state_d;
  logic [IW-1:0]       last_grant_q;
  logic [IW-1:0]       grant_id_q;
  logic [ADDR_W-1:0]   addr_q;
  logic [DATA_W-1:0]   data_q;
  logic [CNT_W-1:0]    tmo_q;
  logic                err_q;
  logic [CNT_W-1:0]    txn_cnt_q;
  logic [CNT_W-1:0]    err_cnt_q;

  logic [NUM_REQ-1:0]  arb_grant;
  logic [IW-1:0]       arb_idx;
  logic                arb_any;
  logic [ADDR_W-1:0]   sel_addr;
  logic [DATA_W-1:0]   sel_data;
  logic                accept;
  logic                tmo_last;

  rr_arbiter #(
    .NUM_REQ (NUM_REQ)
  ) u_rr (
    .req        (req_valid),
    .last_grant (last_grant_q),
    .grant      (arb_grant),
    .grant_idx  (arb_idx),
    .any_valid  (arb_any)
  );

  // Winner's address and data picked out of the packed buses.
  always_comb begin
    sel_addr = '0;
    sel_data = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (arb_grant[i]) begin
        sel_addr = req_addr[i*ADDR_W +: ADDR_W];
        sel_data = req_data[i*DATA_W +: DATA_W];
      end
    end
  end

  assign accept   = (state_q == IDLE) && arb_any;
  assign tmo_last = (tmo_q == TMO_LAST);

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next state and handshake outputs; ack beats a same-cycle timeout.
  always_comb begin
    state_d   = state_q;
    req_ready = '0;
    unique case (state_q)
      IDLE: begin
        req_ready = arb_grant;
        if (arb_any) state_d = WAIT;
      end
      WAIT: begin
        if (slv_ack || tmo_last) state_d = RESP;
      end
      RESP: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Capture the accepted write and remember who was served.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      addr_q       <= '0;
      data_q       <= '0;
      grant_id_q   <= '0;
      last_grant_q <= LG_RST;
    end else if (accept) begin
      addr_q       <= sel_addr;
      data_q       <= sel_data;
      grant_id_q   <= arb_idx;
      last_grant_q <= arb_idx;
    end
  end

  // Cycles spent waiting for the slave in the current transaction.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tmo_q <= '0;
    end else if (accept) begin
      tmo_q <= '0;
    end else if (state_q == WAIT && !slv_ack) begin
      tmo_q <= tmo_q + 1'b1;
    end
  end

  // Response error: slave error on ack, forced high on timeout.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err_q <= 1'b0;
    end else if (accept) begin
      err_q <= 1'b0;
    end else if (state_q == WAIT) begin
      if (slv_ack) begin
        err_q <= slv_err;
      end else if (tmo_last) begin
        err_q <= 1'b1;
      end
    end
  end

  // Completed-transaction and error statistics.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      txn_cnt_q <= '0;
      err_cnt_q <= '0;
    end else if (state_q == RESP) begin
      txn_cnt_q <= txn_cnt_q + 1'b1;
      if (err_q && (err_cnt_q != '1)) begin
        err_cnt_q <= err_cnt_q + 1'b1;
      end
    end
  end

  assign slv_req   = (state_q == WAIT);
  assign slv_addr  = addr_q;
  assign slv_data  = data_q;
  assign busy      = (state_q != IDLE);
  assign grant_id  = grant_id_q;
  assign rsp_valid = (state_q == RESP) ? (NUM_REQ'(1) << grant_id_q) : '0;
  assign rsp_err   = (state_q == RESP) && err_q;
  assign txn_count = txn_cnt_q;
  assign err_count = err_cnt_q;

endmodule
